// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the shared ALU.
// Ports: clk, reset_n, start/op_a/op_b in, alu_* to/from ALU, busy/done/result/flags out.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] alu_result,
  output logic        alu_req,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0011;

  state_t      state, state_nx;
  logic [31:0] p, p_nx;
  logic [31:0] m, m_nx;
  logic [31:0] q, q_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [31:0] res_nx;
  logic [1:0]  flags_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= 2'b01;
    end else begin
      state  <= state_nx;
      p      <= p_nx;
      m      <= m_nx;
      q      <= q_nx;
      cnt    <= cnt_nx;
      result <= res_nx;
      flags  <= flags_nx;
    end
  end

  always_comb begin
    state_nx = state;
    p_nx     = p;
    m_nx     = m;
    q_nx     = q;
    cnt_nx   = cnt;
    res_nx   = result;
    flags_nx = flags;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          p_nx   = '0;
          m_nx   = op_a;
          q_nx   = op_b;
          cnt_nx = '0;
          if (op_b == '0) begin
            state_nx = DONE;
            res_nx   = '0;
            flags_nx = 2'b01;
          end else begin
            state_nx = RUN;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        p_nx   = alu_result;
        m_nx   = m << 1;
        q_nx   = q >> 1;
        cnt_nx = cnt + 6'd1;
        // Stop once no multiplier bits remain or all 32 are consumed.
        if (q[31:1] == '0 || cnt == 6'd31) begin
          state_nx = DONE;
          res_nx   = alu_result;
          flags_nx = {alu_result[31], alu_result == '0};
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_req  = (state == RUN);
    busy     = (state == RUN);
    done     = (state == DONE);
    alu_a    = (state == RUN) ? p : '0;
    alu_b    = (state == RUN && q[0]) ? m : '0;
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU and product model.
// Drives directed and random multiplies, checks timing, datapath and results.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_result;
  logic        alu_req;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  flags;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] exp_res = '0;
  logic [1:0]  exp_flags = 2'b01;

  alu_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .op_a(op_a), .op_b(op_b), .alu_result(alu_result),
    .alu_req(alu_req), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b),
    .busy(busy), .done(done),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_req"}, {31'd0, alu_req}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, alu_ctrl}, 32'd3);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_flags"}, {30'd0, flags}, 32'd1);
  endtask

  // Caller has set start/op_a/op_b; the next edge accepts them.
  task automatic track(input logic [31:0] a, input logic [31:0] b,
                       input bit glitch, input bit chain,
                       input logic [31:0] na, input logic [31:0] nb);
    int k;
    longint unsigned prod, msk, pa, pb;
    logic [31:0] pr;
    k = 0;
    for (int i = 31; i >= 0; i--)
      if (b[i]) begin k = i + 1; break; end
    prod = longint'(a) * longint'(b);
    pr = prod[31:0];
    for (int c = 1; c <= 40; c++) begin
      step();
      start = 1'b0;
      if (glitch && c == 2) begin
        start = 1'b1;
        op_a = 32'd9;
        op_b = 32'd9;
      end
      chk("busy", {31'd0, busy}, {31'd0, c <= k});
      chk("alu_req", {31'd0, alu_req}, {31'd0, c <= k});
      chk("done", {31'd0, done}, {31'd0, c == k + 1});
      chk("alu_ctrl", {28'd0, alu_ctrl}, 32'd3);
      if (c <= k) begin
        msk = (64'd1 << (c - 1)) - 64'd1;
        pa = longint'(a) * (longint'(b) & msk);
        pb = b[c-1] ? (longint'(a) << (c - 1)) : 64'd0;
        chk("alu_a", alu_a, pa[31:0]);
        chk("alu_b", alu_b, pb[31:0]);
        chk("result_held", result, exp_res);
      end else begin
        exp_res = pr;
        exp_flags = {pr[31], pr == 32'd0};
        chk("result", result, exp_res);
        chk("flags", {30'd0, flags}, {30'd0, exp_flags});
        if (chain) begin
          start = 1'b1;
          op_a = na;
          op_b = nb;
        end
        break;
      end
    end
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a = a;
    op_b = b;
    track(a, b, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset_n = 1'b0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    step();
    step();
    chk_reset_outs("reset");
    reset_n = 1'b1;
    step();
    chk_reset_outs("idle");

    mul(32'd3, 32'd5);
    step();
    chk("idle_after_done", {31'd0, done}, 32'd0);
    mul(32'h12345678, 32'd0);
    mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    mul(32'h80000000, 32'd2);
    mul(32'h7FFFFFFF, 32'd3);
    mul(32'hFFFFFFFF, 32'd1);
    step();

    start = 1'b1;
    op_a = 32'd6;
    op_b = 32'd7;
    track(32'd6, 32'd7, 1'b1, 1'b1, 32'd2, 32'd2);
    track(32'd2, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    start = 1'b1;
    op_a = 32'hFFFF;
    op_b = 32'hFFFF;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_res = '0;
    exp_flags = 2'b01;
    chk_reset_outs("midrun_reset");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_done_after_reset", {31'd0, done}, 32'd0);
      chk("no_busy_after_reset", {31'd0, busy}, 32'd0);
    end
    mul(32'd4, 32'd4);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 3) rb = '0;
      mul(ra, rb);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that borrows the shared 32-bit ALU to compute the low 32 bits of an unsigned product by shift-and-add, one ALU ADD per cycle. It sits beside the execute stage. It takes a start pulse with two operands, drives the ALU's control and source ports while busy, and returns a registered result with N/Z flags and a one-cycle done pulse. When idle it drives the ALU ports to a fixed safe value, so the execute-stage mux can select on `alu_req`.

## Interface
- No parameters. Width is fixed at 32; ALU opcode ADD = 4'b0011.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `reset_n  in  1` — synchronous, active-low reset.
- `start  in  1` — request a multiply; sampled only in IDLE or DONE.
- `op_a  in  32` — multiplicand; sampled on the edge that accepts `start`.
- `op_b  in  32` — multiplier; sampled on the edge that accepts `start`.
- `alu_result  in  32` — combinational result from the shared ALU.
- `alu_req  out  1` — high in RUN; the ALU is owned by this block that cycle.
- `alu_ctrl  out  4` — 4'b0011 in every state.
- `alu_a  out  32` — accumulator P in RUN; 0 otherwise.
- `alu_b  out  32` — `Q[0] ? M : 0` in RUN; 0 otherwise.
- `busy  out  1` — high in RUN.
- `done  out  1` — high for exactly one cycle, in DONE.
- `result  out  32` — product, low 32 bits; held until the next accepted start.
- `flags  out  2` — {N, Z} of `result`; held with `result`.

## Operation
- States: IDLE, RUN, DONE. Registers: P[31:0], M[31:0], Q[31:0], cnt[5:0], result, flags.
- Start acceptance (IDLE or DONE, `start`=1), on the accepting edge:
  - P←0, M←op_a, Q←op_b, cnt←0.
  - If op_b==0: go to DONE with result←0, flags←{0,1}.
  - Otherwise go to RUN.
- `start` while in RUN is ignored; it has no effect on the in-flight operation.
- Each RUN cycle (one iteration):
  - The ALU computes P + (Q[0] ? M : 0).
  - At the edge: P←alu_result, M←M<<1 (shift-out discarded), Q←Q>>1, cnt←cnt+1.
- RUN exit: at the edge where (Q>>1)==0 or cnt==31, go to DONE.
  - Also at that edge: result←alu_result, flags←{alu_result[31], alu_result==0}.
- Early exit: iterations k = index of MSB of op_b, plus 1 (1..32).
- Arithmetic: modulo 2^32. ALU carry/overflow are not observed, and no overflow indication is produced.
- DONE: `done`=1 for one cycle.
  - Next state is RUN/DONE if `start` is accepted that cycle, else IDLE.
  - `result` and `flags` remain stable in IDLE.

## Timing
- Reset (reset_n=0 at an edge), including mid-RUN:
  - State←IDLE; P, M, Q, cnt, result←0; flags←{0,1}.
  - `busy`, `done`, `alu_req`←0; `alu_a`, `alu_b`←0.
  - The in-flight operation is discarded and no `done` is issued.
- Latency, with start accepted at edge 0:
  - `busy` rises after edge 0.
  - `done` is high in the cycle after edge k, i.e. k+1 cycles after start.
  - For op_b==0, `done` is high in the cycle after edge 0.
- `result` and `flags` update on the same edge that raises `done`.
- Back-to-back: start in the DONE cycle is accepted, with no idle bubble; `done` still pulses for the finished operation.
- `alu_req`, `alu_a`, `alu_b`, `busy`, and `done` are decoded from registered state only. They are glitch-free with respect to `start`.

## Test plan
- Basic multiply: op_a=3, op_b=5, start at cycle 0.
  - `busy` is high for cycles 1–3.
  - `done` is high in cycle 4 only.
  - result=15, flags=00.
- Zero multiplier: op_b=0, op_a=0x12345678.
  - `done` is high in cycle 1, with no `busy` and no `alu_req`.
  - result=0, flags=01.
- Full length: op_a=op_b=0xFFFFFFFF.
  - 32 RUN cycles; `done` is high in cycle 33.
  - result=0x00000001.
- Wrap and flags:
  - 0x80000000 × 2 → result=0, flags=01, with `done` in cycle 3.
  - 0x7FFFFFFF × 3 → result=0x7FFFFFFD, flags=00.
  - 0xFFFFFFFF × 1 → result=0xFFFFFFFF, flags=10.
- Ignored start and back-to-back:
  - 6×7 started; `start` re-pulsed mid-RUN with 9×9 → no effect; result=42.
  - `start` (2×2) asserted during that DONE cycle → `done` again 3 cycles later, result=4.
- Reset mid-operation: reset_n=0 for one edge during RUN of 0xFFFF×0xFFFF.
  - All outputs go to their reset values, with flags=01.
  - No `done` is issued.
  - A subsequent 4×4 returns 16.
